// File: rtl/pe_pkg.sv
// Shared types and constants for the pe dispatcher and its helpers.
package pe_pkg;

    localparam int Q_INT_BITS  = 7;
    localparam int Q_FRAC_BITS = 9;
    localparam int W           = Q_INT_BITS + Q_FRAC_BITS;
    localparam int PE_CONN_W   = 3;

    typedef logic [W-1:0] q_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } disp_state_e;

endpackage

// File: rtl/pe_disp_counter.sv
// Loadable up/down counter; clear wins over load, load over inc, inc over dec.
module pe_disp_counter #(
    parameter int para_width = 8
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  load,
    input  logic [para_width-1:0] load_val,
    input  logic                  inc,
    input  logic                  dec,
    output logic [para_width-1:0] count
);

    // count register with prioritised controls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + para_width'(1);
        end else if (dec) begin
            count <= count - para_width'(1);
        end
    end

endmodule

// File: rtl/pe_dispatcher.sv
// Sequences one pe_unit through a dot product: accepts operand pairs,
// drives the pe inputs with accumulate/round controls, waits out the pe
// latency and hands the result downstream.
//
// state | meaning
// IDLE  | waiting for start; pe inputs idle, connection_state 0
// ISSUE | taking operand pairs until len beats have been issued
// DRAIN | pe pipeline settling; capture data_out when the delay expires
// OUT   | result presented until the downstream handshake
module pe_dispatcher
    import pe_pkg::*;
#(
    parameter int para_int_bits   = Q_INT_BITS,
    parameter int para_frac_bits  = Q_FRAC_BITS,
    parameter int para_max_len    = 64,
    parameter int para_pe_latency = 1,
    localparam int LW = $clog2(para_max_len + 1),
    localparam int DW = para_int_bits + para_frac_bits
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LW-1:0]        cfg_len,
    input  logic [PE_CONN_W-1:0] cfg_conn,
    output logic                 busy,
    output logic                 err_len,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [DW-1:0]        op_a,
    input  logic [DW-1:0]        op_b,
    output logic [DW-1:0]        pe_data_in_1,
    output logic [DW-1:0]        pe_data_in_2,
    output logic                 pe_adder_en,
    output logic                 pe_rounder_en,
    output logic [PE_CONN_W-1:0] pe_connection_state,
    input  logic [DW-1:0]        pe_data_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [DW-1:0]        res_data
);

    // Drain counter must hold para_pe_latency and stay at least one bit wide.
    localparam int CW = $clog2(para_pe_latency + 2);

    disp_state_e          state, state_nxt;
    logic [LW-1:0]        len_q;
    logic [LW-1:0]        issued;
    logic [PE_CONN_W-1:0] conn_q;
    logic [CW-1:0]        drain_cnt;

    logic                 len_legal;
    logic                 start_ok;
    logic                 beat;
    logic                 last_beat;
    logic                 drain_done;

    logic [DW-1:0]        in1_nxt;
    logic [DW-1:0]        in2_nxt;
    logic                 adder_nxt;
    logic                 rounder_nxt;
    logic                 err_nxt;

    assign len_legal  = (cfg_len != '0) && (cfg_len <= LW'(para_max_len));
    assign start_ok   = (state == IDLE) && start && len_legal;
    assign op_ready   = (state == ISSUE) && (issued < len_q);
    assign beat       = op_valid && op_ready;
    assign last_beat  = beat && (issued == len_q - LW'(1));
    assign drain_done = (state == DRAIN) && (drain_cnt == '0);

    assign busy                = (state != IDLE);
    assign res_valid           = (state == OUT);
    assign pe_connection_state = (state == IDLE) ? '0 : conn_q;

    pe_disp_counter #(.para_width(LW)) u_issue_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (start_ok),
        .load     (1'b0),
        .load_val ('0),
        .inc      (beat),
        .dec      (1'b0),
        .count    (issued)
    );

    pe_disp_counter #(.para_width(CW)) u_drain_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (1'b0),
        .load     (last_beat),
        .load_val (CW'(para_pe_latency)),
        .inc      (1'b0),
        .dec      ((state == DRAIN) && (drain_cnt != '0)),
        .count    (drain_cnt)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and next pe drive; non-beat cycles default to a bubble
    always_comb begin
        state_nxt   = state;
        in1_nxt     = '0;
        in2_nxt     = '0;
        adder_nxt   = 1'b1;
        rounder_nxt = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len_legal) begin
                        state_nxt = ISSUE;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (beat) begin
                    in1_nxt     = op_a;
                    in2_nxt     = op_b;
                    adder_nxt   = (issued != '0);
                    rounder_nxt = last_beat;
                    if (last_beat) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // registered pe drive and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_data_in_1  <= '0;
            pe_data_in_2  <= '0;
            pe_adder_en   <= 1'b1;
            pe_rounder_en <= 1'b0;
            err_len       <= 1'b0;
        end else begin
            pe_data_in_1  <= in1_nxt;
            pe_data_in_2  <= in2_nxt;
            pe_adder_en   <= adder_nxt;
            pe_rounder_en <= rounder_nxt;
            err_len       <= err_nxt;
        end
    end

    // job configuration latched on an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q  <= '0;
            conn_q <= '0;
        end else if (start_ok) begin
            len_q  <= cfg_len;
            conn_q <= cfg_conn;
        end
    end

    // result capture once the pe latency has elapsed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data <= '0;
        end else if (drain_done) begin
            res_data <= pe_data_out;
        end
    end

endmodule

// File: tb/tb_pe_dispatcher.sv
// Bench for pe_dispatcher: directed jobs from the plan plus randomized jobs,
// with a behavioural pe_unit and a dot-product reference model.
module tb_pe_dispatcher;

    localparam int LAT  = 1;
    localparam int LW   = 7;
    localparam int FRAC = 9;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [LW-1:0] cfg_len;
    logic [2:0]  cfg_conn;
    logic        busy;
    logic        err_len;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] pe_data_in_1;
    logic [15:0] pe_data_in_2;
    logic        pe_adder_en;
    logic        pe_rounder_en;
    logic [2:0]  pe_connection_state;
    logic [15:0] pe_data_out;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;

    int n_checks;
    int n_fail;

    logic [15:0] op_a_arr [64];
    logic [15:0] op_b_arr [64];

    pe_dispatcher dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .cfg_len             (cfg_len),
        .cfg_conn            (cfg_conn),
        .busy                (busy),
        .err_len             (err_len),
        .op_valid            (op_valid),
        .op_ready            (op_ready),
        .op_a                (op_a),
        .op_b                (op_b),
        .pe_data_in_1        (pe_data_in_1),
        .pe_data_in_2        (pe_data_in_2),
        .pe_adder_en         (pe_adder_en),
        .pe_rounder_en       (pe_rounder_en),
        .pe_connection_state (pe_connection_state),
        .pe_data_out         (pe_data_out),
        .res_valid           (res_valid),
        .res_ready           (res_ready),
        .res_data            (res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Q-format product, truncated back to the operand scaling
    function automatic int q_mul(input logic [15:0] a, input logic [15:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p >>> FRAC;
    endfunction

    // behavioural pe_unit with one cycle of latency
    int pe_acc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_acc      <= 0;
            pe_data_out <= '0;
        end else if (pe_adder_en) begin
            pe_acc      <= pe_acc + q_mul(pe_data_in_1, pe_data_in_2);
            pe_data_out <= 16'(pe_acc + q_mul(pe_data_in_1, pe_data_in_2));
        end else begin
            pe_acc      <= q_mul(pe_data_in_1, pe_data_in_2);
            pe_data_out <= 16'(q_mul(pe_data_in_1, pe_data_in_2));
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        chk_eq({tag, "_busy"},      32'(busy), 32'd0);
        chk_eq({tag, "_err"},       32'(err_len), 32'd0);
        chk_eq({tag, "_op_ready"},  32'(op_ready), 32'd0);
        chk_eq({tag, "_in1"},       32'(pe_data_in_1), 32'd0);
        chk_eq({tag, "_in2"},       32'(pe_data_in_2), 32'd0);
        chk_eq({tag, "_adder"},     32'(pe_adder_en), 32'd1);
        chk_eq({tag, "_rounder"},   32'(pe_rounder_en), 32'd0);
        chk_eq({tag, "_conn"},      32'(pe_connection_state), 32'd0);
        chk_eq({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk_eq({tag, "_res_data"},  32'(res_data), 32'd0);
    endtask

    // pe drive expected one cycle after a beat (or a bubble when none)
    task automatic check_pe(input bit was_beat, input int idx, input int len, input logic [2:0] conn);
        if (was_beat) begin
            chk_eq("pe_in1_beat",     32'(pe_data_in_1), 32'(op_a_arr[idx]));
            chk_eq("pe_in2_beat",     32'(pe_data_in_2), 32'(op_b_arr[idx]));
            chk_eq("pe_adder_beat",   32'(pe_adder_en), 32'(idx != 0));
            chk_eq("pe_rounder_beat", 32'(pe_rounder_en), 32'(idx == len - 1));
        end else begin
            chk_eq("pe_in1_bubble",     32'(pe_data_in_1), 32'd0);
            chk_eq("pe_in2_bubble",     32'(pe_data_in_2), 32'd0);
            chk_eq("pe_adder_bubble",   32'(pe_adder_en), 32'd1);
            chk_eq("pe_rounder_bubble", 32'(pe_rounder_en), 32'd0);
        end
        chk_eq("pe_conn", 32'(pe_connection_state), 32'(conn));
    endtask

    // One complete job; called and returns at a negedge with the DUT idle.
    // gap_mode: 0 back-to-back, 1 two idle cycles between beats, 2 random.
    // exp_fixed >= 0 overrides the reference-model result.
    task automatic run_job(input int len, input logic [2:0] conn, input int gap_mode,
                           input int hold, input bit start_in_out, input int exp_fixed);
        int          sum;
        logic [15:0] exp_res;
        int          k;
        int          prev_k;
        int          gap_left;
        int          cyc;
        bit          beat_prev;
        bit          valid_now;

        sum = 0;
        for (int i = 0; i < len; i++) sum += q_mul(op_a_arr[i], op_b_arr[i]);
        exp_res = (exp_fixed >= 0) ? 16'(exp_fixed) : 16'(sum);

        start    = 1'b1;
        cfg_len  = LW'(len);
        cfg_conn = conn;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk_eq("busy_after_start", 32'(busy), 32'd1);

        k = 0; prev_k = 0; gap_left = 0; cyc = 0; beat_prev = 1'b0;
        while (k < len && cyc < 2000) begin
            check_pe(beat_prev, prev_k, len, conn);
            chk_eq("op_ready_issue", 32'(op_ready), 32'd1);
            if (gap_mode == 1 && gap_left > 0) begin
                valid_now = 1'b0;
                gap_left--;
            end else if (gap_mode == 2) begin
                valid_now = ($urandom_range(0, 2) != 0);
            end else begin
                valid_now = 1'b1;
            end
            op_valid = valid_now;
            if (valid_now) begin
                op_a = op_a_arr[k];
                op_b = op_b_arr[k];
            end else begin
                op_a = 16'($urandom);
                op_b = 16'($urandom);
            end
            @(posedge clk);
            beat_prev = valid_now;
            if (valid_now) begin
                prev_k   = k;
                k++;
                gap_left = 2;
            end
            @(negedge clk);
            cyc++;
        end
        if (k < len) chk_eq("issue_timeout", 32'(k), 32'(len));
        op_valid = 1'b0;
        op_a     = 16'($urandom);
        op_b     = 16'($urandom);

        for (int d = 1; d <= LAT + 2; d++) begin
            check_pe(d == 1, len - 1, len, conn);
            chk_eq("op_ready_drain", 32'(op_ready), 32'd0);
            chk_eq("busy_drain", 32'(busy), 32'd1);
            chk_eq("res_valid_latency", 32'(res_valid), 32'(d == LAT + 2));
            if (d < LAT + 2) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        chk_eq("res_data", 32'(res_data), 32'(exp_res));

        res_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            if (start_in_out && h == 1) begin
                start    = 1'b1;
                cfg_len  = LW'(2);
                cfg_conn = ~conn;
            end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            chk_eq("res_valid_hold", 32'(res_valid), 32'd1);
            chk_eq("res_data_hold", 32'(res_data), 32'(exp_res));
            chk_eq("busy_hold", 32'(busy), 32'd1);
            chk_eq("conn_hold", 32'(pe_connection_state), 32'(conn));
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk_eq("res_valid_after_ack", 32'(res_valid), 32'd0);
        chk_eq("busy_after_ack", 32'(busy), 32'd0);
        chk_eq("conn_after_ack", 32'(pe_connection_state), 32'd0);
        chk_eq("op_ready_after_ack", 32'(op_ready), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs;
        int bad_len [2];

        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_len   = '0;
        cfg_conn  = '0;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        res_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 1.0*1.0 + 2.0*1.0 + 0.5*4.0 = 5.0
        op_a_arr[0] = 16'h0200; op_b_arr[0] = 16'h0200;
        op_a_arr[1] = 16'h0400; op_b_arr[1] = 16'h0200;
        op_a_arr[2] = 16'h0100; op_b_arr[2] = 16'h0800;
        run_job(3, 3'd2, 0, 0, 1'b0, 32'h0A00);
        run_job(3, 3'd2, 1, 0, 1'b0, 32'h0A00);

        // -1.0 * 3.0 = -3.0
        op_a_arr[0] = 16'hFE00; op_b_arr[0] = 16'h0600;
        run_job(1, 3'd5, 0, 0, 1'b0, 32'hFA00);

        bad_len[0] = 0;
        bad_len[1] = 65;
        for (int b = 0; b < 2; b++) begin
            start    = 1'b1;
            cfg_len  = LW'(bad_len[b]);
            cfg_conn = 3'd7;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            errs  = 0;
            for (int c = 0; c < 3; c++) begin
                errs += int'(err_len);
                chk_eq("busy_bad_len", 32'(busy), 32'd0);
                chk_eq("op_ready_bad_len", 32'(op_ready), 32'd0);
                @(posedge clk);
                @(negedge clk);
            end
            chk_eq("err_len_pulses", 32'(errs), 32'd1);
        end

        // result held under back-pressure, start during OUT ignored,
        // then a fresh job accepted straight after the handshake
        for (int i = 0; i < 4; i++) begin
            op_a_arr[i] = 16'($urandom);
            op_b_arr[i] = 16'($urandom);
        end
        run_job(4, 3'd3, 0, 5, 1'b1, -1);
        run_job(2, 3'd6, 0, 0, 1'b0, -1);

        // reset in the middle of ISSUE after two of four beats
        for (int i = 0; i < 4; i++) begin
            op_a_arr[i] = 16'($urandom);
            op_b_arr[i] = 16'($urandom);
        end
        start    = 1'b1;
        cfg_len  = LW'(4);
        cfg_conn = 3'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            op_valid = 1'b1;
            op_a     = op_a_arr[i];
            op_b     = op_b_arr[i];
            @(posedge clk);
            @(negedge clk);
        end
        chk_eq("mid_job_in1", 32'(pe_data_in_1), 32'(op_a_arr[1]));
        op_a = op_a_arr[2];
        op_b = op_b_arr[2];
        #2 rst_n = 1'b0;
        #1 check_reset("reset_mid");
        op_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op_a_arr[0] = 16'h0300; op_b_arr[0] = 16'h0200;
        op_a_arr[1] = 16'hFF00; op_b_arr[1] = 16'h0400;
        run_job(2, 3'd1, 0, 1, 1'b0, 32'h0100);

        // randomized jobs, first one at the maximum length
        for (int j = 0; j < 8; j++) begin
            int len;
            len = (j == 0) ? 64 : int'($urandom_range(1, 64));
            for (int i = 0; i < len; i++) begin
                op_a_arr[i] = 16'($urandom);
                op_b_arr[i] = 16'($urandom);
            end
            run_job(len, 3'($urandom), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 4)), 1'($urandom), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
